lcd_pixel_writer: RTL and testbench

Downstream consumer of the screen RGB444 pixel stream. It drives an 8080-style 8-bit parallel LCD panel (ILI9341-class) from that stream.
- After reset it performs panel hard reset and a fixed init command sequence.
- Per frame it issues the column, page and memory-write commands, then serializes each pixel as two RGB565 bytes.
- Runs entirely in the clk_100 domain; the pixel source throttles on pix_ready.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_pixel_writer_bus.sv | 66 ++++++
 rtl/lcd_pixel_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_lcd_pixel_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD pixel writer: panel command
// codes, controller states, command-table layout and colour conversion.
package lcd_pkg;

  // ILI9341-class command codes
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  // Controller states
  typedef enum logic [2:0] {
    ST_RST_LO    = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_SLEEP_OUT = 3'd2,
    ST_WAKE      = 3'd3,
    ST_INIT      = 3'd4,
    ST_IDLE      = 3'd5,
    ST_ADDR      = 3'd6,
    ST_PIXEL     = 3'd7
  } lcd_state_e;

  // Command-table index ranges (table entries are {d_c, byte})
  localparam logic [4:0] SEQ_SLPOUT     = 5'd0;
  localparam logic [4:0] SEQ_INIT_FIRST = 5'd1;
  localparam logic [4:0] SEQ_INIT_LAST  = 5'd5;
  localparam logic [4:0] SEQ_ADDR_FIRST = 5'd6;
  localparam logic [4:0] SEQ_ADDR_LAST  = 5'd16;

  // Expand RGB444 to RGB565 by replicating the top bits into the new LSBs
  function automatic logic [15:0] rgb444_to_565(input logic [3:0] r,
                                                input logic [3:0] g,
                                                input logic [3:0] b);
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

endpackage

// File: rtl/lcd_pixel_writer_bus.sv
// Single-byte 8080 write engine. A byte period is WR_LOW cycles with the
// strobe low followed by WR_HIGH cycles high; data and d_c are launched
// with the falling strobe and held for the whole period.
// Handshake: a request is taken in any cycle where i_req=1 and the engine
// is idle or in the last cycle of its period (o_last_cycle=1), so
// back-to-back bytes run with no gap.
module lcd_bus_writer #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_dc,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_last_cycle,
  output logic [7:0] o_lcd_db,
  output logic       o_lcd_wr,
  output logic       o_lcd_d_c
);

  localparam int PERIOD = WR_LOW + WR_HIGH;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_LOW_END = CW'(WR_LOW - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic [7:0]    r_db;
  logic          r_dc;
  logic          w_last;
  logic          w_accept;

  assign w_last   = r_busy && (r_cnt == CNT_LAST);
  assign w_accept = i_req && (!r_busy || w_last);

  // Byte-period sequencer; reset drops the strobe high immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_wr   <= 1'b1;
      r_db   <= 8'h00;
      r_dc   <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_wr   <= 1'b0;
      r_db   <= i_data;
      r_dc   <= i_dc;
    end else if (r_busy) begin
      if (w_last) r_busy <= 1'b0;
      else        r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == CNT_LOW_END) r_wr <= 1'b1;
    end
  end

  assign o_busy       = r_busy;
  assign o_last_cycle = w_last;
  assign o_lcd_db     = r_db;
  assign o_lcd_wr     = r_wr;
  assign o_lcd_d_c    = r_dc;

endmodule

// File: rtl/lcd_pixel_writer.sv
// Drives an 8080 8-bit LCD panel from an RGB444 pixel stream: hard reset,
// fixed init sequence, then per frame the window/RAMWR commands followed by
// two RGB565 bytes per pixel.
// Pixel handshake: a pixel transfers in a cycle where pix_valid and
// pix_ready are both 1; the source holds pixel fields stable until then.
module lcd_pixel_writer
  import lcd_pkg::*;
#(
  parameter int         WIDTH       = 320,
  parameter int         HEIGHT      = 240,
  parameter int         WR_LOW      = 2,
  parameter int         WR_HIGH     = 2,
  parameter int         RST_CYCLES  = 1000000,
  parameter int         WAKE_CYCLES = 12000000,
  parameter logic [7:0] MADCTL      = 8'h28
) (
  input  logic       clk_100,
  input  logic       resetN,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       pix_sof,
  input  logic [3:0] pix_r,
  input  logic [3:0] pix_g,
  input  logic [3:0] pix_b,
  output logic [7:0] lcd_db,
  output logic       lcd_wr,
  output logic       lcd_d_c,
  output logic       lcd_rd,
  output logic       lcd_reset,
  output logic       init_done,
  output logic       frame_done,
  output lcd_state_e dbg_state
);

  localparam logic [19:0] FRAME_PIX = 20'(WIDTH * HEIGHT);
  localparam logic [15:0] W_END     = 16'(WIDTH - 1);
  localparam logic [15:0] H_END     = 16'(HEIGHT - 1);
  localparam logic [31:0] RST_END   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] WAKE_END  = 32'(WAKE_CYCLES - 1);

  lcd_state_e  r_state;
  logic [31:0] r_dly;
  logic [4:0]  r_idx;
  logic        r_seq_sent;
  logic [19:0] r_pix_cnt;
  logic        r_lo_pend;
  logic [7:0]  r_lo_byte;
  logic        r_lcd_reset;
  logic        r_init_done;
  logic        r_frame_done;

  logic        w_busy;
  logic        w_last;
  logic        w_can;
  logic        w_req;
  logic        w_dc;
  logic [7:0]  w_data;
  logic        w_wr_acc;
  logic        w_in_seq;
  logic        w_seq_last;
  logic        w_pix_acc;
  logic        w_sof_bad;
  logic        w_frame_full;
  logic [15:0] w_pix565;
  logic [8:0]  w_entry;

  // Constant command table: {d_c, byte}
  function automatic logic [8:0] seq_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    return {1'b0, CMD_SLPOUT};
      5'd1:    return {1'b0, CMD_COLMOD};
      5'd2:    return {1'b1, 8'h55};
      5'd3:    return {1'b0, CMD_MADCTL};
      5'd4:    return {1'b1, MADCTL};
      5'd5:    return {1'b0, CMD_DISPON};
      5'd6:    return {1'b0, CMD_CASET};
      5'd7:    return {1'b1, 8'h00};
      5'd8:    return {1'b1, 8'h00};
      5'd9:    return {1'b1, W_END[15:8]};
      5'd10:   return {1'b1, W_END[7:0]};
      5'd11:   return {1'b0, CMD_PASET};
      5'd12:   return {1'b1, 8'h00};
      5'd13:   return {1'b1, 8'h00};
      5'd14:   return {1'b1, H_END[15:8]};
      5'd15:   return {1'b1, H_END[7:0]};
      5'd16:   return {1'b0, CMD_RAMWR};
      default: return 9'h000;
    endcase
  endfunction

  assign w_can        = !w_busy || w_last;
  assign w_wr_acc     = w_req && w_can;
  assign w_entry      = seq_entry(r_idx);
  assign w_pix565     = rgb444_to_565(pix_r, pix_g, pix_b);
  assign w_frame_full = (r_pix_cnt == FRAME_PIX);
  // A sof anywhere but pixel 0 means the source restarted its frame
  assign w_sof_bad    = pix_valid && pix_sof && (r_pix_cnt != 20'd0);
  assign w_pix_acc    = (r_state == ST_PIXEL) && pix_valid && pix_ready;
  assign w_in_seq     = (r_state == ST_SLEEP_OUT) || (r_state == ST_INIT) ||
                        (r_state == ST_ADDR);

  // End-of-table index for the active command sequence
  always_comb begin
    w_seq_last = 1'b0;
    case (r_state)
      ST_SLEEP_OUT: w_seq_last = (r_idx == SEQ_SLPOUT);
      ST_INIT:      w_seq_last = (r_idx == SEQ_INIT_LAST);
      ST_ADDR:      w_seq_last = (r_idx == SEQ_ADDR_LAST);
      default:      w_seq_last = 1'b0;
    endcase
  end

  // Upstream throttle: open in IDLE (except on sof) and in PIXEL slots
  always_comb begin
    pix_ready = 1'b0;
    case (r_state)
      ST_IDLE:  pix_ready = !(pix_valid && pix_sof);
      ST_PIXEL: pix_ready = w_can && !r_lo_pend && !w_frame_full && !w_sof_bad;
      default:  pix_ready = 1'b0;
    endcase
  end

  // Byte source for the bus writer: command table, then pixel bytes
  always_comb begin
    w_req  = 1'b0;
    w_dc   = 1'b0;
    w_data = 8'h00;
    if (w_in_seq && !r_seq_sent) begin
      w_req  = 1'b1;
      w_dc   = w_entry[8];
      w_data = w_entry[7:0];
    end else if (r_state == ST_PIXEL) begin
      if (r_lo_pend) begin
        w_req  = 1'b1;
        w_dc   = 1'b1;
        w_data = r_lo_byte;
      end else if (w_pix_acc) begin
        w_req  = 1'b1;
        w_dc   = 1'b1;
        w_data = w_pix565[15:8];
      end
    end
  end

  // Controller FSM, delay counter, table index and pixel counter
  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_RST_LO;
      r_dly        <= '0;
      r_idx        <= '0;
      r_seq_sent   <= 1'b0;
      r_pix_cnt    <= '0;
      r_lo_pend    <= 1'b0;
      r_lo_byte    <= 8'h00;
      r_lcd_reset  <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_in_seq && w_wr_acc && !w_seq_last) r_idx <= r_idx + 5'd1;
      case (r_state)
        ST_RST_LO: begin
          if (r_dly == RST_END) begin
            r_dly       <= '0;
            r_lcd_reset <= 1'b1;
            r_state     <= ST_RST_WAIT;
          end else r_dly <= r_dly + 32'd1;
        end
        ST_RST_WAIT: begin
          if (r_dly == WAKE_END) begin
            r_dly   <= '0;
            r_idx   <= SEQ_SLPOUT;
            r_state <= ST_SLEEP_OUT;
          end else r_dly <= r_dly + 32'd1;
        end
        ST_SLEEP_OUT: begin
          if (w_wr_acc && w_seq_last) r_seq_sent <= 1'b1;
          if (r_seq_sent && w_last) begin
            r_seq_sent <= 1'b0;
            r_state    <= ST_WAKE;
          end
        end
        ST_WAKE: begin
          if (r_dly == WAKE_END) begin
            r_dly   <= '0;
            r_idx   <= SEQ_INIT_FIRST;
            r_state <= ST_INIT;
          end else r_dly <= r_dly + 32'd1;
        end
        ST_INIT: begin
          if (w_wr_acc && w_seq_last) r_seq_sent <= 1'b1;
          if (r_seq_sent && w_last) begin
            r_seq_sent  <= 1'b0;
            r_init_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pix_valid && pix_sof) begin
            r_idx   <= SEQ_ADDR_FIRST;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_wr_acc && w_seq_last) r_state <= ST_PIXEL;
        end
        ST_PIXEL: begin
          if (w_pix_acc) begin
            r_pix_cnt <= r_pix_cnt + 20'd1;
            r_lo_pend <= 1'b1;
            r_lo_byte <= w_pix565[7:0];
          end else if (r_lo_pend && w_can) begin
            r_lo_pend <= 1'b0;
          end else if (w_can && w_frame_full) begin
            r_frame_done <= 1'b1;
            r_pix_cnt    <= '0;
            r_state      <= ST_IDLE;
          end else if (w_can && w_sof_bad) begin
            r_pix_cnt <= '0;
            r_idx     <= SEQ_ADDR_FIRST;
            r_state   <= ST_ADDR;
          end
        end
        default: r_state <= ST_RST_LO;
      endcase
    end
  end

  lcd_bus_writer #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_bus (
    .i_clk        (clk_100),
    .i_rst_n      (resetN),
    .i_req        (w_req),
    .i_dc         (w_dc),
    .i_data       (w_data),
    .o_busy       (w_busy),
    .o_last_cycle (w_last),
    .o_lcd_db     (lcd_db),
    .o_lcd_wr     (lcd_wr),
    .o_lcd_d_c    (lcd_d_c)
  );

  assign lcd_rd     = 1'b1;
  assign lcd_reset  = r_lcd_reset;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Bench for lcd_pixel_writer with a small panel (4x2) and short delays.
// Every byte latched by the panel (rising lcd_wr) is popped from exp_q.
module tb_lcd_pixel_writer;
  import lcd_pkg::*;

  localparam int T_WIDTH  = 4;
  localparam int T_HEIGHT = 2;
  localparam int T_WRLOW  = 2;
  localparam int T_WRHIGH = 2;
  localparam int T_RST    = 4;
  localparam int T_WAKE   = 8;

  logic       clk_100;
  logic       resetN;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_sof;
  logic [3:0] pix_r;
  logic [3:0] pix_g;
  logic [3:0] pix_b;
  logic [7:0] lcd_db;
  logic       lcd_wr;
  logic       lcd_d_c;
  logic       lcd_rd;
  logic       lcd_reset;
  logic       init_done;
  logic       frame_done;
  lcd_state_e dbg_state;

  logic [8:0] exp_q[$];
  int         n_checks;
  int         n_errors;
  int         cyc;
  int         frames;
  int         wr_falls;
  int         last_acc;

  lcd_pixel_writer #(
    .WIDTH       (T_WIDTH),
    .HEIGHT      (T_HEIGHT),
    .WR_LOW      (T_WRLOW),
    .WR_HIGH     (T_WRHIGH),
    .RST_CYCLES  (T_RST),
    .WAKE_CYCLES (T_WAKE),
    .MADCTL      (8'h28)
  ) dut (
    .clk_100    (clk_100),
    .resetN     (resetN),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .lcd_db     (lcd_db),
    .lcd_wr     (lcd_wr),
    .lcd_d_c    (lcd_d_c),
    .lcd_rd     (lcd_rd),
    .lcd_reset  (lcd_reset),
    .init_done  (init_done),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  initial cyc = 0;
  always @(posedge clk_100) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_565(input logic [3:0] r, input logic [3:0] g,
                                          input logic [3:0] b);
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

  // ---------------- scoreboard push helpers ----------------
  task automatic push_init();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h36});
    exp_q.push_back({1'b1, 8'h28});
    exp_q.push_back({1'b0, 8'h29});
  endtask

  task automatic push_addr();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h03});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  // ---------------- bus monitor ----------------
  logic       prev_wr;
  int         low_cnt;
  int         high_cnt;
  bit         seen_byte;
  logic [8:0] cap;
  logic [8:0] exp_b;

  always @(negedge clk_100) begin
    if (!resetN) begin
      prev_wr   = 1'b1;
      low_cnt   = 0;
      high_cnt  = 0;
      seen_byte = 1'b0;
    end else begin
      if (prev_wr && !lcd_wr) begin
        if (seen_byte) check("wr_high_min", 32'(high_cnt >= T_WRHIGH), 32'd1);
        cap     = {lcd_d_c, lcd_db};
        low_cnt = 1;
        wr_falls++;
      end else if (!prev_wr && !lcd_wr) begin
        low_cnt++;
      end else if (!prev_wr && lcd_wr) begin
        check("wr_low_width", 32'(low_cnt), 32'(T_WRLOW));
        check("db_stable", 32'({lcd_d_c, lcd_db}), 32'(cap));
        if (exp_q.size() == 0) begin
          check("byte_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte", 32'(cap), 32'(exp_b));
        end
        seen_byte = 1'b1;
        high_cnt  = 1;
      end else begin
        high_cnt++;
      end
      prev_wr = lcd_wr;
      if (frame_done) frames++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic sof, input bit to_panel);
    logic [15:0] p;
    int n;
    pix_r = r; pix_g = g; pix_b = b; pix_sof = sof; pix_valid = 1'b1;
    if (to_panel && sof) push_addr();
    n = 0;
    while (n < 400) begin
      @(negedge clk_100);
      if (pix_ready) break;
      n++;
    end
    if (n >= 400) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      last_acc = cyc;
      if (to_panel) begin
        p = exp_565(r, g, b);
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic end_stream();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk_100);
      n++;
    end
    check("init_done", 32'(init_done), 32'd1);
    check("init_bytes_all_sent", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_100);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge clk_100);
  endtask

  task automatic release_reset();
    int n;
    @(negedge clk_100);
    resetN = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk_100);
      n++;
      #1;
      if (lcd_reset) break;
    end
    check("lcd_reset_low_cycles", 32'(n), 32'(T_RST));
  endtask

  // ---------------- main sequence ----------------
  int          acc[8];
  int          f0;
  logic [3:0]  cr[8];
  logic [3:0]  cg[8];
  logic [3:0]  cb[8];

  initial begin
    n_checks = 0; n_errors = 0; frames = 0; wr_falls = 0; last_acc = 0;
    resetN = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_r = 4'h0; pix_g = 4'h0; pix_b = 4'h0;
    repeat (3) @(negedge clk_100);

    // reset values
    check("rst_lcd_reset", 32'(lcd_reset), 32'd0);
    check("rst_lcd_wr", 32'(lcd_wr), 32'd1);
    check("rst_lcd_rd", 32'(lcd_rd), 32'd1);
    check("rst_lcd_d_c", 32'(lcd_d_c), 32'd0);
    check("rst_lcd_db", 32'(lcd_db), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // power-up: hard reset and init sequence
    push_init();
    release_reset();
    wait_init();
    @(negedge clk_100);
    check("idle_ready", 32'(pix_ready), 32'd1);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // non-sof pixels in IDLE are swallowed without bus activity
    f0 = wr_falls;
    for (int i = 0; i < 3; i++)
      drive_pixel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end_stream();
    repeat (10) @(negedge clk_100);
    check("idle_no_wr", 32'(wr_falls), 32'(f0));

    // full frame: primaries then random pixels, continuous stream
    cr[0] = 4'hF; cg[0] = 4'h0; cb[0] = 4'h0;
    cr[1] = 4'h0; cg[1] = 4'hF; cb[1] = 4'h0;
    cr[2] = 4'h0; cg[2] = 4'h0; cb[2] = 4'hF;
    for (int i = 3; i < 8; i++) begin
      cr[i] = 4'($urandom_range(0, 15));
      cg[i] = 4'($urandom_range(0, 15));
      cb[i] = 4'($urandom_range(0, 15));
    end
    f0 = frames;
    for (int i = 0; i < 8; i++) begin
      drive_pixel(cr[i], cg[i], cb[i], (i == 0), 1'b1);
      acc[i] = last_acc;
    end
    end_stream();
    for (int i = 1; i < 8; i++)
      check("pixel_rate", 32'(acc[i] - acc[i-1]), 32'(2 * (T_WRLOW + T_WRHIGH)));
    wait_drain();
    check("frame_done_count", 32'(frames - f0), 32'd1);
    check("frame_end_state", 32'(dbg_state), 32'(ST_IDLE));
    check("frame_end_ready", 32'(pix_ready), 32'd1);

    // resync: sof arrives as pixel 3 of a frame
    f0 = frames;
    for (int i = 0; i < 3; i++)
      drive_pixel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), (i == 0), 1'b1);
    drive_pixel(4'h5, 4'hA, 4'h3, 1'b1, 1'b1);
    check("resync_no_frame_done", 32'(frames - f0), 32'd0);
    for (int i = 1; i < 8; i++)
      drive_pixel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b0, 1'b1);
    end_stream();
    wait_drain();
    check("resync_frame_done_count", 32'(frames - f0), 32'd1);

    // reset while a pixel byte has the strobe low
    drive_pixel(4'h9, 4'h6, 4'hC, 1'b1, 1'b1);
    end_stream();
    begin
      int n;
      n = 0;
      while (lcd_wr && n < 100) begin
        @(negedge clk_100);
        n++;
      end
      check("mid_pixel_wr_low", 32'(lcd_wr), 32'd0);
    end
    #2;
    resetN = 1'b0;
    #1;
    check("abort_lcd_wr", 32'(lcd_wr), 32'd1);
    check("abort_lcd_reset", 32'(lcd_reset), 32'd0);
    check("abort_pix_ready", 32'(pix_ready), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_100);
    push_init();
    release_reset();
    wait_init();

    repeat (4) @(negedge clk_100);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
